// File: rtl/voting_pkg.sv
`default_nettype none
// voting_pkg: shared encodings and width helpers for the ballot entry frontend.
// Rev 1.0
package voting_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_ID_LO       = 3'd1;
    localparam logic [2:0] ST_ID_READY    = 3'd2;
    localparam logic [2:0] ST_AUTH_WAIT   = 3'd3;
    localparam logic [2:0] ST_SELECT      = 3'd4;
    localparam logic [2:0] ST_CONFIRM     = 3'd5;
    localparam logic [2:0] ST_RESULT_WAIT = 3'd6;

    localparam logic [1:0] OUT_NONE     = 2'b00;
    localparam logic [1:0] OUT_ACCEPTED = 2'b01;
    localparam logic [1:0] OUT_REJECTED = 2'b10;
    localparam logic [1:0] OUT_TIMEOUT  = 2'b11;

    localparam logic [7:0] CTRL_STATUS_AUTH = 8'h01;

    // Bit positions of the conditioned inputs inside the debouncer bank.
    localparam int IDX_AUTH    = 0;
    localparam int IDX_SUBMIT  = 1;
    localparam int IDX_RESULTS = 2;
    localparam int IDX_CLEAR   = 3;
    localparam int IDX_KEY     = 4;
    localparam int NUM_INPUTS  = 5;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// input_debouncer: 2-FF synchroniser plus consecutive-mismatch debounce with a one-cycle rise event.
// Rev 1.0
module input_debouncer
    import voting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_q     <= 1'b0;
            count      <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_meta  <= raw;
            sync_q     <= sync_meta;
            rise_pulse <= 1'b0;
            if (sync_q == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                // Only a 0->1 flip is an event; releases are silent.
                level      <= sync_q;
                count      <= '0;
                rise_pulse <= sync_q;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ballot_entry_frontend.sv
`default_nettype none
// ballot_entry_frontend: debounced booth inputs, ID/candidate assembly and controller handshake sequencing.
// Rev 1.0
module ballot_entry_frontend
    import voting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_auth_raw,
    input  logic       btn_submit_raw,
    input  logic       btn_results_raw,
    input  logic       btn_clear_raw,
    input  logic       key_press_raw,
    input  logic [3:0] key_code,
    input  logic       system_ready,
    input  logic [7:0] ctrl_status,
    input  logic       vote_accepted,
    input  logic       vote_rejected,
    output logic [7:0] voter_id_input,
    output logic [3:0] candidate_selection,
    output logic       authenticate_voter,
    output logic       submit_vote,
    output logic       display_results_request,
    output logic [2:0] entry_state,
    output logic [1:0] last_outcome
);

    localparam int              TMO_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // Reset asserts asynchronously everywhere but releases two clocks later, in step with clk.
    logic [1:0] rst_pipe;
    logic       rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_pipe <= 2'b11;
        else       rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst = rst_pipe[1];

    logic [NUM_INPUTS-1:0] raw_vec;
    logic [NUM_INPUTS-1:0] level_unused;
    logic [NUM_INPUTS-1:0] rise_vec;

    assign raw_vec[IDX_AUTH]    = btn_auth_raw;
    assign raw_vec[IDX_SUBMIT]  = btn_submit_raw;
    assign raw_vec[IDX_RESULTS] = btn_results_raw;
    assign raw_vec[IDX_CLEAR]   = btn_clear_raw;
    assign raw_vec[IDX_KEY]     = key_press_raw;

    generate
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
            input_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk        (clk),
                .reset      (rst),
                .raw        (raw_vec[i]),
                .level      (level_unused[i]),
                .rise_pulse (rise_vec[i])
            );
        end
    endgenerate

    logic ev_auth, ev_submit, ev_results, ev_clear, ev_key;
    assign ev_auth    = rise_vec[IDX_AUTH];
    assign ev_submit  = rise_vec[IDX_SUBMIT];
    assign ev_results = rise_vec[IDX_RESULTS];
    assign ev_clear   = rise_vec[IDX_CLEAR];
    assign ev_key     = rise_vec[IDX_KEY];

    logic [3:0] key_meta, key_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            key_meta <= key_code;
            key_sync <= key_meta;
        end
    end

    logic [2:0]       state, state_n;
    logic [7:0]       id_n;
    logic [3:0]       cand_n;
    logic [1:0]       outcome_n;
    logic             auth_n, submit_n, accepted;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;

    always_comb begin
        state_n   = state;
        id_n      = voter_id_input;
        cand_n    = candidate_selection;
        outcome_n = last_outcome;
        auth_n    = 1'b0;
        submit_n  = 1'b0;
        accepted  = 1'b0;

        if (!system_ready || ev_clear) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ev_key) begin
                    id_n[7:4] = key_sync;
                    outcome_n = OUT_NONE;
                    state_n   = ST_ID_LO;
                    accepted  = 1'b1;
                end
                ST_ID_LO: if (ev_key) begin
                    id_n[3:0] = key_sync;
                    state_n   = ST_ID_READY;
                    accepted  = 1'b1;
                end
                ST_ID_READY: if (ev_auth) begin
                    auth_n   = 1'b1;
                    state_n  = ST_AUTH_WAIT;
                    accepted = 1'b1;
                end
                ST_AUTH_WAIT: begin
                    if (vote_rejected) begin
                        outcome_n = OUT_REJECTED;
                        state_n   = ST_IDLE;
                    end else if (ctrl_status == CTRL_STATUS_AUTH) begin
                        state_n = ST_SELECT;
                    end
                end
                ST_SELECT: if (ev_key) begin
                    cand_n   = key_sync;
                    state_n  = ST_CONFIRM;
                    accepted = 1'b1;
                end
                ST_CONFIRM: begin
                    if (ev_key) begin
                        cand_n   = key_sync;
                        accepted = 1'b1;
                    end else if (ev_submit) begin
                        submit_n = 1'b1;
                        state_n  = ST_RESULT_WAIT;
                        accepted = 1'b1;
                    end
                end
                ST_RESULT_WAIT: begin
                    if (vote_accepted) begin
                        outcome_n = OUT_ACCEPTED;
                        state_n   = ST_IDLE;
                    end else if (vote_rejected) begin
                        outcome_n = OUT_REJECTED;
                        state_n   = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase

            // Timeout only fires when nothing else moved the FSM this cycle.
            if (state != ST_IDLE && !accepted && state_n == state && tmo_cnt == TMO_LAST) begin
                state_n   = ST_IDLE;
                outcome_n = OUT_TIMEOUT;
            end
        end

        if (state_n == ST_IDLE) begin
            id_n   = '0;
            cand_n = '0;
        end

        tmo_n = (state == ST_IDLE || state_n != state || accepted) ? '0 : tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= ST_IDLE;
            tmo_cnt                 <= '0;
            voter_id_input          <= '0;
            candidate_selection     <= '0;
            last_outcome            <= OUT_NONE;
            authenticate_voter      <= 1'b0;
            submit_vote             <= 1'b0;
            display_results_request <= 1'b0;
        end else begin
            state                   <= state_n;
            tmo_cnt                 <= tmo_n;
            voter_id_input          <= id_n;
            candidate_selection     <= cand_n;
            last_outcome            <= outcome_n;
            authenticate_voter      <= auth_n;
            submit_vote             <= submit_n;
            display_results_request <= system_ready & ev_results;
        end
    end

    assign entry_state = state;

endmodule
`default_nettype wire

// File: tb/tb_ballot_entry_frontend.sv
`default_nettype none
// tb_ballot_entry_frontend: directed scenarios with a pulse scoreboard and direct state checks.
// Rev 1.0
module tb_ballot_entry_frontend;

    localparam int DB = 4;
    localparam int TO = 64;

    localparam int K_AUTH    = 0;
    localparam int K_SUBMIT  = 1;
    localparam int K_RESULTS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] raw = '0;   // 0 auth, 1 submit, 2 results, 3 clear, 4 key
    logic [3:0] key_code = '0;
    logic       system_ready = 1'b1;
    logic [7:0] ctrl_status = '0;
    logic       vote_accepted = 1'b0;
    logic       vote_rejected = 1'b0;

    logic [7:0] voter_id_input;
    logic [3:0] candidate_selection;
    logic       authenticate_voter, submit_vote, display_results_request;
    logic [2:0] entry_state;
    logic [1:0] last_outcome;

    ballot_entry_frontend #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .btn_auth_raw            (raw[0]),
        .btn_submit_raw          (raw[1]),
        .btn_results_raw         (raw[2]),
        .btn_clear_raw           (raw[3]),
        .key_press_raw           (raw[4]),
        .key_code                (key_code),
        .system_ready            (system_ready),
        .ctrl_status             (ctrl_status),
        .vote_accepted           (vote_accepted),
        .vote_rejected           (vote_rejected),
        .voter_id_input          (voter_id_input),
        .candidate_selection     (candidate_selection),
        .authenticate_voter      (authenticate_voter),
        .submit_vote             (submit_vote),
        .display_results_request (display_results_request),
        .entry_state             (entry_state),
        .last_outcome            (last_outcome)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic press(input int idx, input logic [3:0] key);
        @(negedge clk);
        key_code = key;
        raw[idx] = 1'b1;
        cycles(DB + 6);
        raw[idx] = 1'b0;
        cycles(DB + 6);
    endtask

    task automatic enter_id(input logic [7:0] id);
        press(4, id[7:4]);
        press(4, id[3:0]);
    endtask

    task automatic reach_confirm(input logic [7:0] id, input logic [3:0] cand);
        enter_id(id);
        expect_pulse(K_AUTH, id);
        press(0, 4'h0);
        ctrl_status = 8'h01;
        cycles(2);
        ctrl_status = 8'h00;
        press(4, cand);
        check("reach_confirm_state", 32'(entry_state), 32'd5);
    endtask

    // Scoreboard monitor: every output pulse must match the oldest outstanding expectation.
    int         mon_kind;
    logic [7:0] mon_data;
    exp_t       mon_exp;

    always @(negedge clk) begin
        if (!reset && (authenticate_voter || submit_vote || display_results_request)) begin
            if (authenticate_voter && submit_vote) begin
                total++;
                $display("FAIL auth_submit_overlap: got both pulses, required at most one");
            end
            mon_kind = authenticate_voter ? K_AUTH : (submit_vote ? K_SUBMIT : K_RESULTS);
            mon_data = authenticate_voter ? voter_id_input :
                       (submit_vote ? {4'h0, candidate_selection} : 8'h00);
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: got kind %0d data %0h, required no pulse", mon_kind, mon_data);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_exp.kind == mon_kind && mon_exp.data == mon_data) passed++;
                else $display("FAIL pulse_mismatch: got kind %0d data %0h, required kind %0d data %0h",
                              mon_kind, mon_data, mon_exp.kind, mon_exp.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset values
        cycles(3);
        check("rst_state",   32'(entry_state), 32'd0);
        check("rst_outcome", 32'(last_outcome), 32'd0);
        check("rst_id",      32'(voter_id_input), 32'd0);
        check("rst_pulses",  32'({authenticate_voter, submit_vote, display_results_request}), 32'd0);
        reset = 1'b0;
        cycles(5);

        // 1: short glitch on key input must not register
        @(negedge clk); raw[4] = 1'b1;
        @(negedge clk); raw[4] = 1'b0;
        @(negedge clk); raw[4] = 1'b1;
        @(negedge clk); raw[4] = 1'b0;
        cycles(12);
        check("glitch_state", 32'(entry_state), 32'd0);

        // 2: full accepted vote
        press(4, 4'hA);
        check("id_hi_state", 32'(entry_state), 32'd1);
        press(4, 4'h5);
        check("id_ready_state", 32'(entry_state), 32'd2);
        check("id_value", 32'(voter_id_input), 32'hA5);
        expect_pulse(K_AUTH, 8'hA5);
        press(0, 4'h0);
        check("auth_wait_state", 32'(entry_state), 32'd3);
        ctrl_status = 8'h01;
        cycles(2);
        ctrl_status = 8'h00;
        check("select_state", 32'(entry_state), 32'd4);
        press(4, 4'h2);
        check("confirm_state", 32'(entry_state), 32'd5);
        check("cand_value", 32'(candidate_selection), 32'h2);
        expect_pulse(K_SUBMIT, 8'h02);
        press(1, 4'h0);
        check("result_wait_state", 32'(entry_state), 32'd6);
        vote_accepted = 1'b1;
        @(negedge clk);
        vote_accepted = 1'b0;
        check("accept_state",   32'(entry_state), 32'd0);
        check("accept_outcome", 32'(last_outcome), 32'd1);
        check("accept_id_clr",  32'({voter_id_input, candidate_selection}), 32'd0);

        // 3: rejection while waiting for authentication
        press(4, 4'h1);
        check("outcome_cleared_on_key", 32'(last_outcome), 32'd0);
        press(4, 4'h2);
        expect_pulse(K_AUTH, 8'h12);
        press(0, 4'h0);
        vote_rejected = 1'b1;
        @(negedge clk);
        vote_rejected = 1'b0;
        check("reject_state",   32'(entry_state), 32'd0);
        check("reject_outcome", 32'(last_outcome), 32'd2);

        // 4: idle timeout in ID_READY, exact edge
        press(4, 4'h3);
        @(negedge clk);
        key_code = 4'hC;
        raw[4]   = 1'b1;
        n = 0;
        while (entry_state != 3'd2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("tmo_reached_ready", 32'(entry_state), 32'd2);
        check("tmo_id_value", 32'(voter_id_input), 32'h3C);
        raw[4] = 1'b0;
        cycles(TO - 1);
        check("tmo_not_yet", 32'(entry_state), 32'd2);
        cycles(1);
        check("tmo_state",   32'(entry_state), 32'd0);
        check("tmo_outcome", 32'(last_outcome), 32'd3);

        // 5: clear and submit on the same cycle, clear wins
        reach_confirm(8'h77, 4'h9);
        @(negedge clk);
        raw[3] = 1'b1;
        raw[1] = 1'b1;
        cycles(DB + 6);
        raw[3] = 1'b0;
        raw[1] = 1'b0;
        cycles(DB + 6);
        check("clear_state",   32'(entry_state), 32'd0);
        check("clear_outcome", 32'(last_outcome), 32'd0);
        check("clear_cand",    32'(candidate_selection), 32'd0);

        // 6: system_ready drop, then results latency
        reach_confirm(8'h42, 4'h1);
        @(negedge clk);
        system_ready = 1'b0;
        @(negedge clk);
        check("ready_drop_state", 32'(entry_state), 32'd0);
        press(2, 4'h0);
        cycles(2);
        system_ready = 1'b1;
        expect_pulse(K_RESULTS, 8'h00);
        @(negedge clk);
        raw[2] = 1'b1;
        for (int e = 0; e <= DB + 3; e++) begin
            @(negedge clk);
            if (e == DB + 1) check("results_early", 32'(display_results_request), 32'd0);
            if (e == DB + 2) check("results_pulse", 32'(display_results_request), 32'd1);
            if (e == DB + 3) check("results_once",  32'(display_results_request), 32'd0);
        end
        raw[2] = 1'b0;
        cycles(DB + 6);
        check("results_state", 32'(entry_state), 32'd0);

        cycles(5);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
